mac_sequencer: RTL and testbench

MAC_SEQUENCER -- requirements
Module: mac_sequencer

---
 rtl/mac_sequencer.sv | 105 ++++++++++
 tb/tb_mac_sequencer.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/mac_sequencer.sv
// Purpose: control FSM that sequences operand loads and accumulate steps for a MAC datapath.
// Latency: start accepted in cycle 0 gives done in cycle 2*L+2 (cycle 2 when L=0), with in_valid held high.
// Backpressure: in_valid low in FETCH stalls the sequence; abort returns to IDLE on the next edge.
module mac_sequencer #(
    parameter int CNT_WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic [CNT_WIDTH-1:0] length,
    input  logic                 abort,
    input  logic                 in_valid,
    output logic                 in_ready,
    output logic                 load_en,
    output logic                 acc_clear,
    output logic                 acc_en,
    output logic                 busy,
    output logic                 done,
    output logic [CNT_WIDTH-1:0] count
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_CLEAR = 3'd1,
        S_FETCH = 3'd2,
        S_ACCUM = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t               state_q, state_d;
    logic [CNT_WIDTH-1:0] len_q, len_d;
    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;

    // One extra bit so the last-step compare is correct at length = 2^CNT_WIDTH-1.
    logic [CNT_WIDTH:0]   cnt_inc;

    assign cnt_inc = {1'b0, cnt_q} + (CNT_WIDTH+1)'(1);
    assign count   = cnt_q;

    // State, latched length and step counter; synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= S_IDLE;
            len_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            len_q   <= len_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state and output decode; abort overrides only the transition, so the
    // step performed in the abort cycle (clear or accumulate) is still reflected in count.
    always_comb begin
        state_d   = state_q;
        len_d     = len_q;
        cnt_d     = cnt_q;
        in_ready  = 1'b0;
        load_en   = 1'b0;
        acc_clear = 1'b0;
        acc_en    = 1'b0;
        busy      = (state_q != S_IDLE);
        done      = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    len_d   = length;
                    state_d = S_CLEAR;
                end
            end
            S_CLEAR: begin
                acc_clear = 1'b1;
                cnt_d     = '0;
                state_d   = (len_q == '0) ? S_DONE : S_FETCH;
            end
            S_FETCH: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    load_en = 1'b1;
                    state_d = S_ACCUM;
                end
            end
            S_ACCUM: begin
                acc_en  = 1'b1;
                cnt_d   = cnt_inc[CNT_WIDTH-1:0];
                state_d = (cnt_inc == {1'b0, len_q}) ? S_DONE : S_FETCH;
            end
            S_DONE: begin
                // An abort landing on the final cycle suppresses the completion pulse.
                done    = !abort;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (abort && (state_q != S_IDLE)) begin
            state_d = S_IDLE;
        end
    end

endmodule

// File: tb/tb_mac_sequencer.sv
// Purpose: self-checking bench for mac_sequencer using a schedule-based reference model.
// Latency: model predicts per-cycle outputs from the step schedule derived from length and in_valid.
// Backpressure: in_valid gaps, aborts, reset mid-run and ignored starts are exercised.
module tb_mac_sequencer;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         reset;
    logic         start;
    logic [W-1:0] length;
    logic         abort;
    logic         in_valid;
    logic         in_ready;
    logic         load_en;
    logic         acc_clear;
    logic         acc_en;
    logic         busy;
    logic         done;
    logic [W-1:0] count;

    int tests = 0;
    int fails = 0;
    int prev_cnt = 0;

    bit vpat [1024];
    bit accc [1024];

    mac_sequencer #(.CNT_WIDTH(W)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .length    (length),
        .abort     (abort),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .load_en   (load_en),
        .acc_clear (acc_clear),
        .acc_en    (acc_en),
        .busy      (busy),
        .done      (done),
        .count     (count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [5:0] outs();
        return {in_ready, load_en, acc_clear, acc_en, busy, done};
    endfunction

    task automatic fill_valid(input int mode);
        // mode 0: always valid; mode 1: random (about 2/3 valid) for early cycles
        for (int i = 0; i < 1024; i++) begin
            if (mode == 1 && i < 200) vpat[i] = ($urandom_range(0, 2) != 0);
            else                      vpat[i] = 1'b1;
        end
    endtask

    // One sequence: start in cycle 0. abort_at < 0: none; -2: random abort cycle.
    // Entered and left just after a rising edge.
    task automatic run(input string name, input int L, input int abort_at,
                       input bit rnd_start, input bit abort_with_start);
        int d, t, a, last, ecnt;
        logic [5:0] ev;
        bit live, fetch;
        for (int i = 0; i < 1024; i++) accc[i] = 1'b0;
        // Schedule: each step waits in FETCH for a valid cycle, loads there and accumulates next cycle.
        if (L == 0) begin
            d = 2;
        end else begin
            t = 2;
            for (int k = 0; k < L; k++) begin
                while (!vpat[t]) t++;
                accc[t+1] = 1'b1;
                t += 2;
            end
            d = t;
        end
        if (abort_at == -2)     a = $urandom_range(1, d - 1);
        else if (abort_at < 0)  a = 100000;
        else                    a = abort_at;
        last = ((a < d) ? a : d) + 2;
        ecnt = prev_cnt;
        for (int c = 0; c <= last; c++) begin
            start    = (c == 0) || (rnd_start && c >= 1 && c < d && c <= a && ($urandom_range(0, 1) == 1));
            length   = (c == 0) ? W'(L) : W'($urandom);
            abort    = (c == 0) ? abort_with_start : (c == a);
            in_valid = vpat[c];
            #1;
            live  = (c <= a) && (c <= d);
            fetch = live && c >= 2 && c < d && !accc[c];
            ev = {fetch, fetch && vpat[c], live && c == 1, live && accc[c], live && c >= 1, live && c == d};
            if (c <= 1) begin
                ecnt = prev_cnt;
            end else begin
                ecnt = 0;
                for (int j = 2; j <= c - 1 && j <= a; j++) ecnt += int'(accc[j]);
            end
            check($sformatf("%s outs c%0d", name, c), 32'(outs()), 32'(ev));
            check($sformatf("%s count c%0d", name, c), 32'(count), 32'(ecnt));
            @(posedge clk);
            #1;
        end
        start = 1'b0;
        abort = 1'b0;
        prev_cnt = ecnt;
    endtask

    initial begin
        reset    = 1'b0;
        start    = 1'b0;
        abort    = 1'b0;
        in_valid = 1'b0;
        length   = '0;
        repeat (2) @(posedge clk);
        #1;
        check("reset outs", 32'(outs()), 32'd0);
        check("reset count", 32'(count), 32'd0);
        reset = 1'b1;
        @(posedge clk);
        #1;
        prev_cnt = 0;

        // length 3, valid held: clear c1, loads 2/4/6, accs 3/5/7, done 8, count 3
        fill_valid(0);
        run("len3", 3, -1, 1'b0, 1'b0);
        check("len3 final count", 32'(count), 32'd3);

        // length 2 with 4 invalid cycles in first FETCH
        fill_valid(0);
        for (int i = 2; i < 6; i++) vpat[i] = 1'b0;
        run("len2stall", 2, -1, 1'b0, 1'b0);
        check("len2stall final count", 32'(count), 32'd2);

        // length 0
        fill_valid(0);
        run("len0", 0, -1, 1'b0, 1'b0);
        check("len0 final count", 32'(count), 32'd0);

        // length 5, abort in second ACCUM (cycle 5)
        fill_valid(0);
        run("len5abort", 5, 5, 1'b0, 1'b0);
        check("abort busy", 32'(busy), 32'd0);
        check("abort count", 32'(count), 32'd2);
        run("after_abort", 3, -1, 1'b0, 1'b0);

        // reset during FETCH of a length-4 run, with start and abort also high
        fill_valid(0);
        start = 1'b1; length = 8'd4; in_valid = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        check("len4 in FETCH ready", 32'(in_ready), 32'd1);
        reset = 1'b0; start = 1'b1; abort = 1'b1;
        @(posedge clk); #1;
        check("midreset outs", 32'(outs()), 32'd0);
        check("midreset count", 32'(count), 32'd0);
        reset = 1'b1; start = 1'b0; abort = 1'b0;
        @(posedge clk); #1;
        check("post reset idle", 32'(outs()), 32'd0);
        prev_cnt = 0;
        run("len4_busystart", 4, -1, 1'b1, 1'b0);

        // start together with abort in IDLE still starts
        run("start_abort_idle", 2, -1, 1'b0, 1'b1);

        // full-range length
        fill_valid(0);
        run("len255", 255, -1, 1'b0, 1'b0);
        check("len255 final count", 32'(count), 32'd255);

        // randomized runs
        for (int r = 0; r < 25; r++) begin
            fill_valid(1);
            run($sformatf("rnd%0d", r), $urandom_range(0, 20),
                ($urandom_range(0, 2) == 0) ? -2 : -1,
                1'b1, 1'($urandom_range(0, 1)));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
